// File: rtl/spi_cmd_seq.sv
// Command sequencer in front of the SPI master: queues host commands, issues them
// one at a time, and returns a one-cycle response (data or timeout) for reads.
//
// state   | meaning
// IDLE    | waiting for a queued command
// ISSUE   | presenting the FIFO head to the SPI master until accepted
// WAIT_RD | read issued, waiting for read data or the timeout
module spi_cmd_seq #(
    parameter int CMD_WIDTH  = 12,
    parameter int READ_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CMD_WIDTH-1:0]  req_cmd,
    input  logic                  req_vld,
    output logic                  req_rdy,
    output logic [CMD_WIDTH-1:0]  cmd_out,
    output logic                  cmd_vld,
    input  logic                  cmd_rdy,
    input  logic                  read_vld,
    input  logic [READ_WIDTH-1:0] read_data,
    output logic                  rsp_vld,
    output logic [READ_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t                  state_q, state_d;
    logic [CMD_WIDTH-1:0]    mem_q [DEPTH];
    logic [CMD_WIDTH-1:0]    mem_d [DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic [15:0]             tcnt_q, tcnt_d;
    logic                    rsp_vld_q, rsp_vld_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [READ_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [CMD_WIDTH-1:0]    head;
    logic                    push, pop;

    assign head     = mem_q[rd_ptr_q];
    assign req_rdy  = (count_q != FULL_CNT);
    assign cmd_vld  = (state_q == ISSUE);
    assign cmd_out  = (count_q == '0) ? '0 : head;
    assign busy     = (state_q != IDLE) || (count_q != '0);
    assign push     = req_vld && req_rdy;
    assign pop      = cmd_vld && cmd_rdy;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_data = rsp_data_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = req_cmd;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        rsp_vld_d  = 1'b0;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = ISSUE;
            end
            ISSUE: begin
                if (cmd_rdy) begin
                    tcnt_d  = '0;
                    state_d = head[CMD_WIDTH-1] ? WAIT_RD : IDLE;
                end
            end
            WAIT_RD: begin
                tcnt_d = tcnt_q + 16'd1;
                // Data arriving on the timeout cycle still counts as a good read.
                if (read_vld) begin
                    rsp_vld_d  = 1'b1;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = read_data;
                    state_d    = IDLE;
                end else if (tcnt_q == TO_LAST) begin
                    rsp_vld_d  = 1'b1;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tcnt_q     <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tcnt_q     <= tcnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed bench for spi_cmd_seq: main instance with a long timeout plus a
// TIMEOUT=16 instance sharing the same stimulus for the timeout cases.
module tb_spi_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] req_cmd;
    logic        req_vld;
    logic        cmd_rdy;
    logic        read_vld;
    logic [7:0]  read_data;

    logic        req_rdy, cmd_vld, rsp_vld, rsp_err, busy;
    logic [11:0] cmd_out;
    logic [7:0]  rsp_data;

    logic        req_rdy_b, cmd_vld_b, rsp_vld_b, rsp_err_b, busy_b;
    logic [11:0] cmd_out_b;
    logic [7:0]  rsp_data_b;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit chk_b  = 1'b0;

    logic [11:0] exp_cmd_q [$];
    logic [8:0]  exp_rsp_q [$];
    logic [8:0]  exp_rsp_b_q [$];

    always #5 clk = ~clk;

    spi_cmd_seq #(.CMD_WIDTH(12), .READ_WIDTH(8), .DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_vld(req_vld), .req_rdy(req_rdy),
        .cmd_out(cmd_out), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .read_vld(read_vld),
        .read_data(read_data), .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    spi_cmd_seq #(.CMD_WIDTH(12), .READ_WIDTH(8), .DEPTH(4), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_vld(req_vld), .req_rdy(req_rdy_b),
        .cmd_out(cmd_out_b), .cmd_vld(cmd_vld_b), .cmd_rdy(cmd_rdy), .read_vld(read_vld),
        .read_data(read_data), .rsp_vld(rsp_vld_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
        .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] c, input bit track);
        req_cmd = c;
        req_vld = 1'b1;
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        if (track) exp_cmd_q.push_back(c);
    endtask

    task automatic wait_cmd_vld();
        for (int i = 0; i < 20; i++) begin
            if (cmd_vld) break;
            step();
        end
        check("cmd_vld_wait", {31'd0, cmd_vld}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            step();
        end
        check("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: command order and response contents
    always @(negedge clk) begin
        if (!rst && cmd_vld && cmd_rdy) begin
            if (exp_cmd_q.size() == 0) check("cmd_unexpected", {20'd0, cmd_out}, 32'hFFFF_FFFF);
            else check("cmd_order", {20'd0, cmd_out}, {20'd0, exp_cmd_q.pop_front()});
        end
        if (rsp_vld) begin
            if (exp_rsp_q.size() == 0) check("rsp_unexpected", {31'd0, rsp_vld}, 32'd0);
            else check("rsp_a", {23'd0, rsp_err, rsp_data}, {23'd0, exp_rsp_q.pop_front()});
        end
        if (chk_b && rsp_vld_b) begin
            if (exp_rsp_b_q.size() == 0) check("rsp_b_unexpected", {31'd0, rsp_vld_b}, 32'd0);
            else check("rsp_b", {23'd0, rsp_err_b, rsp_data_b}, {23'd0, exp_rsp_b_q.pop_front()});
        end
    end

    initial begin
        rst = 1'b1; req_cmd = '0; req_vld = 1'b0; cmd_rdy = 1'b0;
        read_vld = 1'b0; read_data = '0;
        step(); step();
        check("rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        check("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        rst = 1'b0;
        step();

        // Single write: cmd_vld two edges after the push, one cycle wide
        cmd_rdy = 1'b1;
        push(12'h03C, 1'b1);
        check("wr_vld_n",   {31'd0, cmd_vld}, 32'd0);
        check("wr_busy_n",  {31'd0, busy},    32'd1);
        step();
        check("wr_vld_n1",  {31'd0, cmd_vld}, 32'd1);
        check("wr_cmd_out", {20'd0, cmd_out}, 32'h03C);
        step();
        check("wr_vld_n2",  {31'd0, cmd_vld}, 32'd0);
        check("wr_busy_n2", {31'd0, busy},    32'd0);
        step(); step();

        // Read answered 20 cycles after acceptance
        push(12'h812, 1'b1);
        wait_cmd_vld();
        step();
        repeat (19) step();
        read_vld = 1'b1; read_data = 8'hA5;
        exp_rsp_q.push_back({1'b0, 8'hA5});
        step();
        read_vld = 1'b0;
        check("rd_rsp_vld",  {31'd0, rsp_vld}, 32'd1);
        check("rd_rsp_data", {24'd0, rsp_data}, 32'hA5);
        check("rd_rsp_err",  {31'd0, rsp_err}, 32'd0);
        step();
        check("rd_rsp_pulse", {31'd0, rsp_vld}, 32'd0);
        wait_idle();

        // Timeout on the TIMEOUT=16 instance
        rst = 1'b1; step(); rst = 1'b0; step();
        chk_b = 1'b1;
        push(12'h8AB, 1'b1);
        wait_cmd_vld();
        step();
        for (int k = 1; k < 16; k++) begin
            check("to_early", {31'd0, rsp_vld_b}, 32'd0);
            step();
        end
        check("to_early_last", {31'd0, rsp_vld_b}, 32'd0);
        exp_rsp_b_q.push_back({1'b1, 8'h00});
        step();
        check("to_rsp_vld",  {31'd0, rsp_vld_b}, 32'd1);
        check("to_rsp_err",  {31'd0, rsp_err_b}, 32'd1);
        check("to_rsp_data", {24'd0, rsp_data_b}, 32'h00);
        step();
        check("to_rsp_pulse", {31'd0, rsp_vld_b}, 32'd0);

        // Data on the timeout cycle wins
        rst = 1'b1; step(); rst = 1'b0; step();
        push(12'h8CD, 1'b1);
        wait_cmd_vld();
        step();
        repeat (15) step();
        read_vld = 1'b1; read_data = 8'h5A;
        exp_rsp_b_q.push_back({1'b0, 8'h5A});
        exp_rsp_q.push_back({1'b0, 8'h5A});
        step();
        read_vld = 1'b0;
        check("tie_rsp_vld",  {31'd0, rsp_vld_b}, 32'd1);
        check("tie_rsp_err",  {31'd0, rsp_err_b}, 32'd0);
        check("tie_rsp_data", {24'd0, rsp_data_b}, 32'h5A);
        step();
        chk_b = 1'b0;
        wait_idle();

        // Backpressure and order
        cmd_rdy = 1'b0;
        push(12'h001, 1'b1);
        push(12'h002, 1'b1);
        push(12'h003, 1'b1);
        check("bp_rdy_3", {31'd0, req_rdy}, 32'd1);
        push(12'h004, 1'b1);
        check("bp_rdy_4", {31'd0, req_rdy}, 32'd0);
        req_cmd = 12'h005; req_vld = 1'b1;
        step(); step();
        check("bp_held_rdy", {31'd0, req_rdy}, 32'd0);
        check("bp_head",     {20'd0, cmd_out}, 32'h001);
        exp_cmd_q.push_back(12'h005);
        cmd_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (req_rdy) begin
                step();
                break;
            end
        end
        req_vld = 1'b0;
        wait_idle();
        check("bp_all_issued", exp_cmd_q.size(), 32'd0);

        // Stray read data in IDLE and during a write ISSUE
        read_vld = 1'b1; read_data = 8'h77;
        step();
        read_vld = 1'b0;
        step();
        check("stray_idle", {31'd0, rsp_vld}, 32'd0);
        cmd_rdy = 1'b0;
        push(12'h055, 1'b1);
        wait_cmd_vld();
        read_vld = 1'b1;
        step();
        read_vld = 1'b0;
        step();
        check("stray_issue", {31'd0, rsp_vld}, 32'd0);
        cmd_rdy = 1'b1;
        wait_idle();

        // Reset in WAIT_RD with two commands queued
        push(12'h8EE, 1'b1);
        wait_cmd_vld();
        step();
        push(12'h011, 1'b0);
        push(12'h022, 1'b0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_vld", {31'd0, cmd_vld}, 32'd0);
        check("mid_rst_busy",    {31'd0, busy},    32'd0);
        check("mid_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        check("mid_rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check("post_rst_busy",    {31'd0, busy},    32'd0);
        check("post_rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        check("post_rst_cmd_out", {20'd0, cmd_out}, 32'h000);
        push(12'h8F0, 1'b1);
        wait_cmd_vld();
        step();
        repeat (2) step();
        read_vld = 1'b1; read_data = 8'h3C;
        exp_rsp_q.push_back({1'b0, 8'h3C});
        step();
        read_vld = 1'b0;
        check("post_rd_vld",  {31'd0, rsp_vld}, 32'd1);
        check("post_rd_data", {24'd0, rsp_data}, 32'h3C);
        step();
        wait_idle();
        check("rsp_q_drained", exp_rsp_q.size(), 32'd0);
        check("cmd_q_drained", exp_cmd_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_cmd_seq.md
# spi_cmd_seq

Command sequencer upstream of the SPI master. It accepts host commands into a small FIFO and issues them one at a time over the master's `cmd_in`/`cmd_vld`/`cmd_rdy` handshake. For read commands it waits for the master's `read_vld`/`read_data`, then returns a one-cycle response to the host, or flags an error if the response times out.

## Interface
- `CMD_WIDTH`, 12: command width; bit `CMD_WIDTH-1` is the read flag (1 = read, 0 = write).
- `READ_WIDTH`, 8: read data width.
- `DEPTH`, 4: command FIFO depth; a power of 2, at least 2.
- `TIMEOUT`, 255: cycles allowed in WAIT_RD before an error response; range 2..65535.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_cmd`  in  CMD_WIDTH  host command.
- `req_vld`  in  1  host command valid.
- `req_rdy`  out  1  FIFO not full.
- `cmd_out`  out  CMD_WIDTH  command to the SPI master; this is the FIFO head.
- `cmd_vld`  out  1  command valid to the SPI master.
- `cmd_rdy`  in  1  SPI master ready.
- `read_vld`  in  1  SPI master read data valid.
- `read_data`  in  READ_WIDTH  SPI master read data.
- `rsp_vld`  out  1  one-cycle response pulse.
- `rsp_data`  out  READ_WIDTH  response data.
- `rsp_err`  out  1  response is a timeout; qualified by `rsp_vld`.
- `busy`  out  1  FIFO not empty, or FSM not in IDLE.

## Operation
- **FIFO**
  - Push when `req_vld && req_rdy`.
  - `req_rdy = (count != DEPTH)`, combinational from the registered count.
  - Pop when `cmd_vld && cmd_rdy`.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
  - `count` is `$clog2(DEPTH)+1` bits wide.
- **FSM states:** IDLE, ISSUE, WAIT_RD.
  - **IDLE:** if count != 0, go to ISSUE; otherwise stay.
  - **ISSUE:** `cmd_vld = 1` and `cmd_out` = FIFO head, held stable until accepted.
    - On `cmd_rdy`: pop the FIFO.
    - Go to WAIT_RD if the head's read flag is 1, else go to IDLE.
    - Without `cmd_rdy`: stay in ISSUE.
  - **WAIT_RD:** timeout counter `tcnt` clears on entry and increments each cycle.
    - If `read_vld`: register `rsp_data <= read_data`, `rsp_err <= 0`, `rsp_vld <= 1`, go to IDLE.
    - Else if `tcnt == TIMEOUT-1`: `rsp_data <= 0`, `rsp_err <= 1`, `rsp_vld <= 1`, go to IDLE.
    - If `read_vld` arrives in the same cycle as the timeout, the data wins and `rsp_err = 0`.
- **Write commands** produce no response.
- **`read_vld` outside WAIT_RD** is ignored; no response is generated.
- **`rsp_vld`** is high for exactly one cycle per read. There is no host backpressure.
- **`cmd_out`** is 0 when the FIFO is empty; its value is don't-care while `cmd_vld = 0`.
- **`busy`** is `(state != IDLE) || (count != 0)`, combinational.
- **Reset**
  - Asynchronous assertion of `rst` forces state to IDLE, clears count, pointers, `tcnt`, `rsp_vld`, `rsp_err` and `rsp_data`, and discards queued commands.
  - During and after reset: `cmd_vld = 0`, `busy = 0`, `req_rdy = 1`.
  - Reset in ISSUE or WAIT_RD drops the transaction with no response pulse.

## Timing
- **Issue latency:** push into an empty FIFO at edge N gives state ISSUE after edge N+1. `cmd_vld` is high in the cycle following edge N+1.
- **Back-to-back writes:** minimum 2 cycles between `cmd_vld` acceptances, because of the ISSUE→IDLE→ISSUE round trip.
- **Read response:** `read_vld` sampled at edge M gives `rsp_vld` high in the cycle after edge M.
- **Timeout:** WAIT_RD entered at edge E gives `rsp_vld` with `rsp_err = 1` in the cycle after edge E+TIMEOUT.
- **`req_rdy` on a full FIFO:** deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after a pop.
- **Registered outputs:** `rsp_*`. **Combinational from registers:** `cmd_vld`, `req_rdy`, `busy`, `cmd_out`.

## Test plan
- **Single write:** push `req_cmd=12'h0_3C`, `cmd_rdy=1`.
  - `cmd_vld` pulses for 1 cycle with `cmd_out=12'h03C`, two edges after the push.
  - No `rsp_vld`; `busy` returns to 0.
- **Read:** push `12'h8_12`, hold `cmd_rdy=1`, drive `read_vld` with `read_data=8'hA5` 20 cycles after acceptance.
  - One `rsp_vld` with `rsp_data=8'hA5`, `rsp_err=0`.
- **Timeout:** `TIMEOUT=16`, push a read, never drive `read_vld`.
  - `rsp_vld=1`, `rsp_err=1`, `rsp_data=0` exactly 16 cycles after WAIT_RD entry.
  - A `read_vld` on the timeout cycle instead gives `rsp_err=0` with its data.
- **Backpressure and order:** `cmd_rdy=0`, push 5 commands 1..5 with `DEPTH=4`.
  - `req_rdy` drops after the 4th; the 5th is held off.
  - Releasing `cmd_rdy` issues commands 1,2,3,4,5 in order.
- **Stray data:** pulse `read_vld` while in IDLE and during a write ISSUE.
  - No `rsp_vld`.
- **Reset mid-operation:** assert `rst` in WAIT_RD with 2 commands queued.
  - All outputs reach reset values immediately; no response.
  - After release, FIFO empty and `req_rdy=1`; a new read completes normally.
